// File: rtl/curve_sim_checker_if.sv
// Result-stream interface between the curve engine (master) and the
// result checker (slave), including the expected-vector ROM lookup.
// Handshake: a beat transfers on a rising clk edge where res_valid and
// res_ready are both high. res_data/res_last are stable while res_valid
// waits for res_ready. exp_data is a combinational function of exp_addr.
interface curve_sim_checker_if;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;

    // Engine / ROM side
    modport master (
        output res_valid, res_data, res_last, exp_data,
        input  res_ready, exp_addr
    );

    // Checker side
    modport slave (
        input  res_valid, res_data, res_last, exp_data,
        output res_ready, exp_addr
    );
endinterface

// File: rtl/curve_sim_checker.sv
// Result scoreboard for the curve-engine bench: compares streamed result
// words against an expected-vector ROM and drives sticky pass/done status
// plus a 32-bit report {code, vec_idx, info}.
// Optional feature: define CHECKER_TIMEOUT_EN to end the run with code 5
// once TIMEOUT cycles have elapsed in RUN.
module curve_sim_checker #(
    parameter int NUM_WORDS   = 8,
    parameter int NUM_VECTORS = 4,
    parameter int TIMEOUT     = 90000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    curve_sim_checker_if.slave   bus,
    output logic                 sim_success,
    output logic                 sim_done,
    output logic [31:0]          sim_report,
    output logic [1:0]           state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_RUN      = 4'd1;
    localparam logic [3:0] C_PASS     = 4'd2;
    localparam logic [3:0] C_MISMATCH = 4'd3;
    localparam logic [3:0] C_FRAMING  = 4'd4;
    localparam logic [3:0] C_TIMEOUT  = 4'd5;

    localparam logic [11:0] LAST_WORD = 12'(NUM_WORDS - 1);
    localparam logic [11:0] LAST_VEC  = 12'(NUM_VECTORS - 1);
    localparam logic [15:0] NW16      = 16'(NUM_WORDS);

    logic [1:0]  state_q, state_d;
    logic [11:0] word_idx_q, word_idx_d;
    logic [11:0] vec_idx_q, vec_idx_d;
    logic [15:0] mis_cnt_q, mis_cnt_d;
    // Only the vector half of first_bad is ever reported, so only it is kept.
    logic [11:0] fb_vec_q, fb_vec_d;
    logic [31:0] report_q, report_d;
    logic        done_q, done_d;
    logic        success_q, success_d;

    logic        beat, is_last_word, is_last_vec;
    logic        frame_err, final_beat, mismatch, tmo;
    logic [15:0] mis_next;
    logic [11:0] fb_vec_next;

`ifdef CHECKER_TIMEOUT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] beats_q, beats_d;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    // Next-state, index, scoreboard and report logic
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        vec_idx_d   = vec_idx_q;
        mis_cnt_d   = mis_cnt_q;
        fb_vec_d    = fb_vec_q;
        report_d    = report_q;
        done_d      = done_q;
        success_d   = success_q;
`ifdef CHECKER_TIMEOUT_EN
        cyc_d       = cyc_q;
        beats_d     = beats_q;
        tmo         = (state_q == S_RUN) && (cyc_q == 32'(TIMEOUT - 1));
`else
        tmo         = 1'b0;
`endif
        beat         = (state_q == S_RUN) && bus.res_valid;
        is_last_word = (word_idx_q == LAST_WORD);
        is_last_vec  = (vec_idx_q == LAST_VEC);
        frame_err    = beat && (bus.res_last != is_last_word);
        final_beat   = beat && !frame_err && is_last_word && is_last_vec;
        mismatch     = beat && !frame_err && (bus.res_data != bus.exp_data);
        mis_next     = (mismatch && mis_cnt_q != 16'hFFFF) ? mis_cnt_q + 16'd1 : mis_cnt_q;
        // A zero count means no mismatch has been latched yet (count saturates, never wraps).
        fb_vec_next  = (mismatch && mis_cnt_q == 16'd0) ? vec_idx_q : fb_vec_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    word_idx_d = '0;
                    vec_idx_d  = '0;
                    mis_cnt_d  = '0;
                    fb_vec_d   = '0;
`ifdef CHECKER_TIMEOUT_EN
                    cyc_d      = '0;
                    beats_d    = '0;
`endif
                end
            end
            S_RUN: begin
                report_d = {C_RUN, vec_idx_q, 4'd0, word_idx_q};
`ifdef CHECKER_TIMEOUT_EN
                cyc_d    = cyc_q + 32'd1;
`endif
                if (frame_err) begin
                    // Offending beat is consumed but not compared; indices stay on it.
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    report_d = {C_FRAMING, vec_idx_q, 4'd0, word_idx_q};
                end else begin
                    if (beat) begin
                        mis_cnt_d = mis_next;
                        fb_vec_d  = fb_vec_next;
`ifdef CHECKER_TIMEOUT_EN
                        beats_d   = beats_q + 16'd1;
`endif
                        if (is_last_word) begin
                            word_idx_d = '0;
                            vec_idx_d  = vec_idx_q + 12'd1;
                        end else begin
                            word_idx_d = word_idx_q + 12'd1;
                        end
                    end
                    // The final beat takes priority over a simultaneous timeout.
                    if (final_beat) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        word_idx_d = word_idx_q;
                        vec_idx_d  = vec_idx_q;
                        if (mis_next == 16'd0) begin
                            success_d = 1'b1;
                            report_d  = {C_PASS, 12'd0, 16'd0};
                        end else begin
                            report_d  = {C_MISMATCH, fb_vec_next, mis_next};
                        end
                    end else if (tmo) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
`ifdef CHECKER_TIMEOUT_EN
                        report_d = {C_TIMEOUT, vec_idx_q, beats_d};
`else
                        report_d = {C_TIMEOUT, vec_idx_q, 16'd0};
`endif
                    end
                end
            end
            default: begin
                // DONE: everything frozen until reset.
            end
        endcase
    end

    // State and scoreboard registers, async active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            vec_idx_q  <= '0;
            mis_cnt_q  <= '0;
            fb_vec_q   <= '0;
            report_q   <= '0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            vec_idx_q  <= vec_idx_d;
            mis_cnt_q  <= mis_cnt_d;
            fb_vec_q   <= fb_vec_d;
            report_q   <= report_d;
            done_q     <= done_d;
            success_q  <= success_d;
        end
    end

`ifdef CHECKER_TIMEOUT_EN
    // Run-length cycle counter and accepted-beat counter for the timeout report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q   <= '0;
            beats_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            beats_q <= beats_d;
        end
    end
`endif

    assign bus.res_ready = (state_q == S_RUN);
    assign bus.exp_addr  = 16'(vec_idx_q) * NW16 + 16'(word_idx_q);
    assign sim_success   = success_q;
    assign sim_done      = done_q;
    assign sim_report    = report_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_curve_sim_checker.sv
// Bench for curve_sim_checker: directed result streams against a modelled
// ROM; expected reports and beat addresses are queued by the stimulus and
// checked by independent monitors.
module tb_curve_sim_checker;
    localparam int NW = 8;
    localparam int NV = 4;
`ifdef CHECKER_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 90000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sim_success, sim_done;
    logic [31:0] sim_report;
    logic [1:0]  state_dbg;
    int          cyc = 0;

    curve_sim_checker_if bus ();

    curve_sim_checker #(.NUM_WORDS(NW), .NUM_VECTORS(NV), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
        .sim_success(sim_success), .sim_done(sim_done),
        .sim_report(sim_report), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return 32'hC0DE_0000 | {16'd0, a};
    endfunction

    assign bus.exp_data = rom_word(bus.exp_addr);

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rep_q[$];
    logic [31:0] exp_succ_q[$];
    logic [31:0] exp_addr_q[$];
    logic        done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Beat monitor: every accepted beat must present the next expected ROM address
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_addr_q.size() == 0) check("beat_unexpected", 32'(bus.exp_addr), 32'hFFFF_FFFF);
            else check("exp_addr", 32'(bus.exp_addr), exp_addr_q.pop_front());
        end
    end

    // Report monitor: on each rising sim_done compare report and success
    always @(negedge clk) begin
        if (sim_done && !done_seen) begin
            done_seen = 1'b1;
            if (exp_rep_q.size() == 0) check("done_unexpected", sim_report, 32'hFFFF_FFFF);
            else begin
                check("sim_report", sim_report, exp_rep_q.pop_front());
                check("sim_success", 32'(sim_success), exp_succ_q.pop_front());
            end
        end else if (!sim_done) begin
            done_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_report", sim_report, 32'd0);
        check("rst_done", 32'(sim_done), 32'd0);
        check("rst_success", 32'(sim_success), 32'd0);
        check("rst_ready", 32'(bus.res_ready), 32'd0);
        check("rst_addr", 32'(bus.exp_addr), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start(output int t0);
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [15:0] a, input int gap);
        bit acc;
        int n;
        repeat (gap) tick();
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        bus.res_last  = l;
        exp_addr_q.push_back(32'(a));
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = bus.res_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
        bus.res_valid = 1'b0;
    endtask

    // Streams vectors; bad_v/bad_w corrupts one word, frm_v/frm_w asserts res_last early
    // and ends the stream there; max_beats truncates the stream.
    task automatic stream(input int bad_v, input int bad_w, input int frm_v, input int frm_w,
                          input bit rnd, input int max_beats);
        int sent = 0;
        for (int v = 0; v < NV; v++) begin
            for (int w = 0; w < NW; w++) begin
                logic [15:0] a;
                logic [31:0] d;
                logic        l;
                bit          frm;
                if (sent >= max_beats) return;
                a   = 16'(v * NW + w);
                frm = (v == frm_v && w == frm_w);
                d   = (v == bad_v && w == bad_w) ? 32'hDEAD_BEEF : rom_word(a);
                l   = (w == NW - 1) || frm;
                send_beat(d, l, a, rnd ? int'($urandom_range(0, 2)) : 0);
                sent++;
                if (frm) return;
            end
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!sim_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!sim_done) check("done_wait_timeout", 32'd0, 32'd1);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_last  = 1'b0;

        // Reset state
        do_reset();
        check("idle_state", 32'(state_dbg), 32'd0);

        // 1) clean stream -> pass
        exp_rep_q.push_back(32'h2000_0000); exp_succ_q.push_back(32'd1);
        pulse_start(t0);
        tick();
        check("run_report", sim_report, 32'h1000_0000);
        check("run_ready", 32'(bus.res_ready), 32'd1);
        stream(-1, -1, -1, -1, 1'b0, 1000);
        wait_done(50);
        check("done_flag", 32'(sim_done), 32'd1);
        check("done_ready_low", 32'(bus.res_ready), 32'd0);
        // start in DONE is ignored
        pulse_start(t0);
        tick();
        check("done_ignores_start", sim_report, 32'h2000_0000);

        // 2) one bad word in vector 2 -> mismatch
        do_reset();
        exp_rep_q.push_back(32'h3002_0001); exp_succ_q.push_back(32'd0);
        pulse_start(t0);
        stream(2, 5, -1, -1, 1'b0, 1000);
        wait_done(50);

        // 3) early res_last at vector 1 word 3 -> framing
        do_reset();
        exp_rep_q.push_back(32'h4001_0003); exp_succ_q.push_back(32'd0);
        pulse_start(t0);
        stream(-1, -1, 1, 3, 1'b0, 1000);
        wait_done(50);
        // a later beat stalls: never accepted, address frozen
        bus.res_valid = 1'b1;
        bus.res_data  = rom_word(16'd12);
        bus.res_last  = 1'b0;
        repeat (4) tick();
        check("frame_ready_low", 32'(bus.res_ready), 32'd0);
        check("frame_addr_frozen", 32'(bus.exp_addr), 32'd11);
        check("frame_report_frozen", sim_report, 32'h4001_0003);
        bus.res_valid = 1'b0;

        // 4) random valid gaps, all good -> pass, addresses 0..31 in order
        do_reset();
        exp_rep_q.push_back(32'h2000_0000); exp_succ_q.push_back(32'd1);
        pulse_start(t0);
        stream(-1, -1, -1, -1, 1'b1, 1000);
        wait_done(50);

`ifdef CHECKER_TIMEOUT_EN
        // 5) engine stalls after 10 beats -> timeout 100 cycles after start
        do_reset();
        exp_rep_q.push_back(32'h5001_000A); exp_succ_q.push_back(32'd0);
        pulse_start(t0);
        stream(-1, -1, -1, -1, 1'b0, 10);
        while (!sim_done && cyc - t0 < 300) @(negedge clk);
        check("timeout_cycle", 32'(cyc - t0), 32'd100);
        tick();
`endif

        // 6) reset mid-run, then a full good stream
        do_reset();
        pulse_start(t0);
        stream(-1, -1, -1, -1, 1'b0, 5);
        do_reset();
        exp_rep_q.push_back(32'h2000_0000); exp_succ_q.push_back(32'd1);
        pulse_start(t0);
        stream(-1, -1, -1, -1, 1'b0, 1000);
        wait_done(50);

        repeat (3) tick();
        check("rep_queue_empty", 32'(exp_rep_q.size()), 32'd0);
        check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global safety bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
